// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and sizes for the snake game board logic.
//   BOARD_ADDR_W : address width of the 32x16 board RAM
//   CELL_W       : width of one board cell word (cell type + body direction)
//   cell_t       : what occupies a board cell
//   owner_e      : which requester a board RAM read belongs to
//   rd_tag_t     : {valid, owner} tag that follows a read through the RAM
// ---------------------------------------------------------------------------
package snake_pkg;

  localparam int BOARD_ADDR_W = 9;
  localparam int CELL_W       = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SNAKE = 2'd1,
    HEAD  = 2'd2,
    FOOD  = 2'd3
  } cell_t;

  typedef enum logic {
    OWN_VGA  = 1'b0,
    OWN_GAME = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Cell type lives in the low two bits of a cell word.
  function automatic cell_t cell_kind(input logic [CELL_W-1:0] word);
    return cell_t'(word[1:0]);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// rd_tag_pipe
// Two-stage shift register carrying the {valid, owner} tag of each board RAM
// read so the returning data can be steered to the requester that asked.
// Stage 1 lines up with the registered RAM command, stage 2 with the cycle
// in which the RAM presents its read data.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset, drops every tag in flight
//   tag_in  : tag of the access granted this cycle
//   tag_out : tag whose read data is on the RAM output this cycle
// ---------------------------------------------------------------------------
module rd_tag_pipe
  import snake_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1  <= '{valid: 1'b0, owner: OWN_VGA};
      tag_out <= '{valid: 1'b0, owner: OWN_VGA};
    end else begin
      stage1  <= tag_in;
      tag_out <= stage1;
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter
// Shares the single-port synchronous board RAM between the VGA renderer
// (read-only, has priority) and the game logic (read/write). A starvation
// counter forces the game through after STARVE_MAX consecutive denials, and
// a tagged read pipeline returns each read's data to the requester that
// issued it, three cycles after its grant.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   vga_req/vga_addr              : renderer read request (held until gnt)
//   vga_gnt                       : renderer accepted this cycle
//   vga_rvalid/vga_rdata          : renderer read return
//   game_req/game_we/game_addr/
//   game_wdata                    : game access request (held until gnt)
//   game_gnt                      : game accepted this cycle
//   game_rvalid/game_rdata        : game read return (reads only)
//   mem_en/mem_we/mem_addr/
//   mem_wdata                     : registered RAM command
//   mem_rdata                     : RAM read data, one cycle after mem_en
// ---------------------------------------------------------------------------
module board_mem_arbiter
  import snake_pkg::*;
#(
  parameter int ADDR_W     = BOARD_ADDR_W,
  parameter int DATA_W     = CELL_W,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  rd_tag_t          tag_in;
  rd_tag_t          tag_ret;
  logic             vga_ret;
  logic             game_ret;

  assign starve_hit = (starve_cnt == CNT_MAX);

  // Grant decision. The renderer wins contention unless the game has been
  // denied STARVE_MAX cycles in a row. Nothing is granted during reset.
  always_comb begin
    vga_gnt  = 1'b0;
    game_gnt = 1'b0;
    if (!rst) begin
      if (vga_req && game_req) begin
        if (starve_hit) begin
          game_gnt = 1'b1;
        end else begin
          vga_gnt = 1'b1;
        end
      end else begin
        vga_gnt  = vga_req;
        game_gnt = game_req;
      end
    end
  end

  // Counts consecutive cycles in which the game waits; any game grant or a
  // withdrawn game request restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!game_req || game_gnt) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered RAM command. Address and write data keep their last value
  // when idle so the RAM pins only toggle on real accesses; a renderer read
  // leaves the write data bus untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (vga_gnt) begin
      mem_en   <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= vga_addr;
    end else if (game_gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= game_we;
      mem_addr  <= game_addr;
      mem_wdata <= game_wdata;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // Only reads get a valid tag; game writes have nothing to return.
  always_comb begin
    tag_in.valid = vga_gnt | (game_gnt & ~game_we);
    tag_in.owner = game_gnt ? OWN_GAME : OWN_VGA;
  end

  rd_tag_pipe u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_ret)
  );

  assign vga_ret  = tag_ret.valid && (tag_ret.owner == OWN_VGA);
  assign game_ret = tag_ret.valid && (tag_ret.owner == OWN_GAME);

  // Steer the returning RAM word to its owner; the other owner's data
  // register keeps its previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rvalid  <= 1'b0;
      game_rvalid <= 1'b0;
      vga_rdata   <= '0;
      game_rdata  <= '0;
    end else begin
      vga_rvalid  <= vga_ret;
      game_rvalid <= game_ret;
      if (vga_ret) begin
        vga_rdata <= mem_rdata;
      end
      if (game_ret) begin
        game_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_mem_arbiter
// Self-checking bench for board_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic. A behavioural model (denial count,
// shadow memory, queue of pending read returns) is compared against the DUT
// on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_board_mem_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 4;
  localparam int STARVE_MAX = 7;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  board_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_gnt     (vga_gnt),
    .vga_rvalid  (vga_rvalid),
    .vga_rdata   (vga_rdata),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_addr   (game_addr),
    .game_wdata  (game_wdata),
    .game_gnt    (game_gnt),
    .game_rvalid (game_rvalid),
    .game_rdata  (game_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i == 5) return 4'h3;
    return 4'(i) ^ 4'h9;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Board RAM: synchronous, write-first, data one cycle after enable.
  logic [DATA_W-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
          mem_rdata <= mem_wdata;
        end else begin
          mem_rdata <= ram[mem_addr];
        end
      end
    end
  end

  // Behavioural model and per-cycle compare.
  typedef struct {
    int                due;
    bit                is_game;
    logic [DATA_W-1:0] data;
  } rd_ret_t;

  initial begin
    logic [DATA_W-1:0] shadow [DEPTH];
    rd_ret_t           pend [$];
    rd_ret_t           r;
    int                cyc;
    int                denied;
    logic              ev, eg, exp_vv, exp_gv;
    logic              e_en, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_vdata, e_gdata;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    cyc = 0; denied = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_vdata = '0; e_gdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_vv = 1'b0;
      exp_gv = 1'b0;
      if (rst) begin
        denied = 0;
        pend.delete();
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_vdata = '0; e_gdata = '0;
        ev = 1'b0;
        eg = 1'b0;
      end else begin
        ev = vga_req && (!game_req || denied < STARVE_MAX);
        eg = game_req && !ev;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          r = pend.pop_front();
          if (r.is_game) begin
            exp_gv = 1'b1; e_gdata = r.data;
          end else begin
            exp_vv = 1'b1; e_vdata = r.data;
          end
        end
      end
      check_output("m_vga_gnt",     32'(vga_gnt),     32'(ev));
      check_output("m_game_gnt",    32'(game_gnt),    32'(eg));
      check_output("m_mem_en",      32'(mem_en),      32'(e_en));
      check_output("m_mem_we",      32'(mem_we),      32'(e_we));
      check_output("m_mem_addr",    32'(mem_addr),    32'(e_addr));
      check_output("m_mem_wdata",   32'(mem_wdata),   32'(e_wdata));
      check_output("m_vga_rvalid",  32'(vga_rvalid),  32'(exp_vv));
      check_output("m_game_rvalid", 32'(game_rvalid), 32'(exp_gv));
      check_output("m_vga_rdata",   32'(vga_rdata),   32'(e_vdata));
      check_output("m_game_rdata",  32'(game_rdata),  32'(e_gdata));
      if (!rst) begin
        if (game_req && !eg) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
        else denied = 0;
        e_en = ev || eg;
        e_we = eg && game_we;
        if (ev) begin
          e_addr = vga_addr;
          pend.push_back('{due: cyc + 3, is_game: 1'b0, data: shadow[vga_addr]});
        end else if (eg) begin
          e_addr  = game_addr;
          e_wdata = game_wdata;
          if (game_we) shadow[game_addr] = game_wdata;
          else pend.push_back('{due: cyc + 3, is_game: 1'b1, data: shadow[game_addr]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random traffic obeying the hold-until-granted handshake.
  task automatic apply_stimulus(input int cycles);
    logic vg, gg;
    int   rst_left;
    rst_left = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      vg = vga_gnt;
      gg = game_gnt;
      tick();
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        rst_left = 2;
      end
      if (!vga_req || vg) begin
        vga_req  = ($urandom_range(0, 99) < 60);
        vga_addr = 9'($urandom_range(0, 15));
      end
      if (!game_req || gg) begin
        game_req   = ($urandom_range(0, 99) < 50);
        game_we    = 1'($urandom_range(0, 1));
        game_addr  = 9'($urandom_range(0, 15));
        game_wdata = 4'($urandom);
      end
    end
    rst = 1'b0;
    vga_req = 1'b0;
    game_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vga_req = 1'b1; vga_addr = '0;
    game_req = 1'b1; game_we = 1'b0; game_addr = '0; game_wdata = '0;

    // Reset values, requests present but suppressed.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_vga_gnt",    32'(vga_gnt),    32'd0);
    check_output("rst_game_gnt",   32'(game_gnt),   32'd0);
    check_output("rst_mem_en",     32'(mem_en),     32'd0);
    check_output("rst_mem_addr",   32'(mem_addr),   32'd0);
    check_output("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    check_output("rst_game_rdata", 32'(game_rdata), 32'd0);
    tick();
    rst = 1'b0; vga_req = 1'b0; game_req = 1'b0;
    tick();

    // Renderer alone reads addr 5 (holds 0x3).
    vga_req = 1'b1; vga_addr = 9'd5;
    @(negedge clk);
    check_output("t1_vga_gnt",  32'(vga_gnt),  32'd1);
    check_output("t1_game_gnt", 32'(game_gnt), 32'd0);
    tick();
    vga_req = 1'b0;
    @(negedge clk);
    check_output("t1_mem_en",   32'(mem_en),   32'd1);
    check_output("t1_mem_addr", 32'(mem_addr), 32'd5);
    tick();
    @(negedge clk);
    check_output("t1_early_rvalid", 32'(vga_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check_output("t1_vga_rvalid", 32'(vga_rvalid), 32'd1);
    check_output("t1_vga_rdata",  32'(vga_rdata),  32'h3);
    tick();

    // Game writes 0xA to addr 17 then reads it back.
    game_req = 1'b1; game_we = 1'b1; game_addr = 9'd17; game_wdata = 4'hA;
    @(negedge clk);
    check_output("t2_wr_gnt", 32'(game_gnt), 32'd1);
    tick();
    game_we = 1'b0;
    @(negedge clk);
    check_output("t2_rd_gnt",    32'(game_gnt),  32'd1);
    check_output("t2_mem_we",    32'(mem_we),    32'd1);
    check_output("t2_mem_wdata", 32'(mem_wdata), 32'hA);
    tick();
    game_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_output("t2_early_rvalid", 32'(game_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check_output("t2_game_rvalid", 32'(game_rvalid), 32'd1);
    check_output("t2_game_rdata",  32'(game_rdata),  32'hA);
    check_output("t2_no_vga",      32'(vga_rvalid),  32'd0);
    tick();

    // Alternating owners back-to-back: VGA 1, game 2, VGA 3.
    vga_req = 1'b1; vga_addr = 9'd1;
    @(negedge clk);
    tick();
    vga_req = 1'b0; game_req = 1'b1; game_we = 1'b0; game_addr = 9'd2;
    @(negedge clk);
    tick();
    game_req = 1'b0; vga_req = 1'b1; vga_addr = 9'd3;
    @(negedge clk);
    tick();
    vga_req = 1'b0;
    @(negedge clk);
    check_output("t3_v1_rvalid", 32'(vga_rvalid),  32'd1);
    check_output("t3_v1_rdata",  32'(vga_rdata),   32'h8);
    check_output("t3_v1_no_g",   32'(game_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check_output("t3_g2_rvalid", 32'(game_rvalid), 32'd1);
    check_output("t3_g2_rdata",  32'(game_rdata),  32'hB);
    check_output("t3_g2_no_v",   32'(vga_rvalid),  32'd0);
    tick();
    @(negedge clk);
    check_output("t3_v3_rvalid", 32'(vga_rvalid), 32'd1);
    check_output("t3_v3_rdata",  32'(vga_rdata),  32'hA);
    tick();

    // Continuous contention: 7 VGA grants, then 1 game grant, repeating.
    vga_req = 1'b1; vga_addr = 9'd7;
    game_req = 1'b1; game_we = 1'b0; game_addr = 9'd9;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check_output("t4_game_gnt", 32'(game_gnt), 32'(i % 8 == 7));
      check_output("t4_vga_gnt",  32'(vga_gnt),  32'(i % 8 != 7));
      tick();
    end
    vga_req = 1'b0; game_req = 1'b0;
    repeat (4) tick();

    // Game withdraws after 4 denials, then must wait the full 7 again.
    vga_req = 1'b1; game_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("t5_denied", 32'(game_gnt), 32'd0);
      tick();
    end
    game_req = 1'b0;
    repeat (2) tick();
    game_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("t5_restart", 32'(game_gnt), 32'(i == 7));
      tick();
    end
    vga_req = 1'b0; game_req = 1'b0;
    repeat (4) tick();

    // Reset with reads in flight and the game partly starved.
    vga_req = 1'b1; vga_addr = 9'd5; game_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t6_pre_vga_gnt", 32'(vga_gnt), 32'd1);
      tick();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("t6_rst_rvalid", 32'(vga_rvalid), 32'd0);
      check_output("t6_rst_mem_en", 32'(mem_en),     32'd0);
      check_output("t6_rst_rdata",  32'(vga_rdata),  32'd0);
      check_output("t6_rst_gnt",    32'(vga_gnt),    32'd0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("t6_post_game_gnt", 32'(game_gnt), 32'(i == 7));
      if (i < 3) check_output("t6_dropped_rvalid", 32'(vga_rvalid), 32'd0);
      tick();
    end
    vga_req = 1'b0; game_req = 1'b0;
    repeat (4) tick();

    $display("[TB] directed scenarios done, starting random traffic");
    apply_stimulus(3000);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Arbitrates a single-port synchronous board RAM between two requesters: the VGA pixel renderer (read-only, latency-sensitive) and the game logic (read/write snake and food cells). It sits between `game` sub-blocks and the board RAM macro. It gives the renderer priority, bounds game-logic starvation with a counter, and returns read data to the correct owner through a tagged read pipeline.

## Interface
Parameters:
- `ADDR_W`, 9, board cell address width (32x16 board)
- `DATA_W`, 4, cell word width (cell type + body direction)
- `STARVE_MAX`, 7, consecutive denied game cycles before game is forced through

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `vga_req`  in  1  renderer read request, held until granted
- `vga_addr`  in  ADDR_W  renderer read address
- `vga_gnt`  out  1  renderer request accepted this cycle (combinational)
- `vga_rvalid`  out  1  `vga_rdata` valid (one-cycle pulse)
- `vga_rdata`  out  DATA_W  renderer read data
- `game_req`  in  1  game access request, held until granted
- `game_we`  in  1  1 = write, 0 = read
- `game_addr`  in  ADDR_W  game address
- `game_wdata`  in  DATA_W  game write data
- `game_gnt`  out  1  game request accepted this cycle (combinational)
- `game_rvalid`  out  1  `game_rdata` valid (one-cycle pulse, reads only)
- `game_rdata`  out  DATA_W  game read data
- `mem_en`, `mem_we`  out  1  RAM enable / write enable (registered)
- `mem_addr`  out  ADDR_W  RAM address (registered)
- `mem_wdata`  out  DATA_W  RAM write data (registered)
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after `mem_en` is sampled

## Operation
- At most one grant per cycle. `vga_gnt` and `game_gnt` are never both high.
- Priority rule, evaluated each cycle:
  - Only one requester is active: grant it.
  - Both active and `starve_cnt < STARVE_MAX`: grant VGA.
  - Both active and `starve_cnt == STARVE_MAX`: grant game.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - increments when `game_req && !game_gnt`
  - clears to 0 on `game_gnt` or when `!game_req`
  - saturates at STARVE_MAX
- Requester handshake: hold req, addr, we and wdata stable while gnt is low. The cycle after gnt, the requester may present a new request or drop req.
- Granted access is registered onto `mem_*` in the next cycle. With no grant, `mem_en=0`, `mem_we=0`, and addr/wdata hold their last value.
- Read tag pipeline: a 2-stage owner tag {valid, owner} travels alongside each read. Writes carry no tag.
- The read returning at stage 2 captures `mem_rdata` into the owner's `*_rdata` register and pulses that owner's `*_rvalid`. The other owner's rdata register holds its value.
- Back-to-back reads from the same or alternating owners are fully pipelined: one grant per cycle, no bubbles.
- Game write followed by a VGA read of the same address on the next grant returns the new data. This follows from RAM write-first ordering and is not re-ordered by the arbiter.
- Reset mid-operation: the tag pipeline clears, so in-flight reads are dropped and no rvalid is issued. `starve_cnt` returns to 0.

## Timing
- Reset values: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `vga_rvalid=0`, `game_rvalid=0`, `vga_rdata=0`, `game_rdata=0`. Both `gnt` outputs are 0 while `rst` is high.
- A grant in cycle N produces:
  - `mem_*` driven in N+1
  - `mem_rdata` valid in N+2
  - `*_rvalid` and `*_rdata` in N+3
- Read latency is exactly 3 cycles from grant. Writes complete at the clock edge ending N+1.
- Under continuous contention, game is granted at least once every STARVE_MAX+1 cycles.
- Under continuous contention, VGA receives exactly STARVE_MAX grants between consecutive game grants.

## Structure
- Shared package `snake_pkg` holds:
  - `BOARD_ADDR_W`, `CELL_W`
  - `cell_t` enum (EMPTY, SNAKE, HEAD, FOOD)
  - `owner_e` enum (OWN_VGA, OWN_GAME) used for the tag
- The arbiter uses `owner_e` for its read tags. The package parameters supply the module's `ADDR_W` and `DATA_W` defaults.
- One sub-module: `rd_tag_pipe`, the 2-stage {valid, owner} shift register with async reset.
- Priority logic and the starvation counter are inline.

## Test plan
- Reset mid-read: grant VGA read, assert `rst` in N+1 → no `vga_rvalid` ever, all outputs 0, `starve_cnt=0`.
- VGA only, addr 5 holding 0x3 → `vga_gnt` in N, `mem_en=1` / `mem_addr=5` in N+1, `vga_rvalid=1` with `vga_rdata=0x3` in N+3.
- Game write then read: write 0xA to addr 17, next cycle read addr 17 → `game_rvalid` with 0xA exactly 3 cycles after the read grant, no `vga_rvalid`.
- Both requesting continuously, STARVE_MAX=7 → grant pattern 7×VGA then 1×game, repeating. Game is never denied 8 consecutive cycles.
- Alternating owners back-to-back (VGA addr 1, game addr 2, VGA addr 3) → rvalids on consecutive cycles, each with the correct owner and data.
- Game drops `game_req` after 4 denied cycles then re-requests → counter restarts from 0, and game waits the full 7 VGA grants again.
